bidir_link_ctrl: RTL and testbench

Initiator-side controller for a half-duplex, word-wide bidirectional link. It owns the direction control of the shared tristate bus: it drives one request word, releases the bus, waits a turnaround gap, then listens for a single response word from the peer or times out. It sits between a parallel valid/ready producer and the bidirectional buffer pads that connect to the peer.

---
 rtl/bidir_link_pkg.sv | 24 ++
 rtl/bidir_link_pad.sv | 26 ++
 rtl/bidir_link_ctrl.sv | 160 ++++++++++++++++
 tb/tb_bidir_link_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bidir_link_pkg.sv
// bidir_link_pkg: shared types and constants for the link initiator.
// even_par is used only when BIDIR_LINK_PARITY_EN is defined.
package bidir_link_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_TURN_CYC = 1;
  localparam int DEF_RX_WIN   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    TURN   = 3'd2,
    LISTEN = 3'd3,
    GAP    = 3'd4
  } state_t;

  // Even parity bit: makes the total count of ones even.
  function automatic logic even_par(
    input logic [63:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/bidir_link_pad.sv
// bidir_link_pad: per-bit tristate drivers for bus and stb.
// Drivers are enabled by dir; resolved pin values are returned.
module bidir_link_pad
  import bidir_link_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic         dir,
  input  logic [W-1:0] dout,
  input  logic         sout,
  output logic [W-1:0] din,
  output logic         sin,
  inout  wire  [W-1:0] bus,
  inout  wire          stb
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    bufif1 u_drv (bus[i], dout[i], dir);
  end

  bufif1 u_stb (stb, sout, dir);

  assign din = bus;
  assign sin = stb;

endmodule

// File: rtl/bidir_link_ctrl.sv
// bidir_link_ctrl: half-duplex initiator, one request then one response.
// Optional macro BIDIR_LINK_PARITY_EN adds an even-parity bit on bus.
module bidir_link_ctrl
  import bidir_link_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TURN_CYC = DEF_TURN_CYC,
  parameter int RX_WIN   = DEF_RX_WIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             timeout,
`ifdef BIDIR_LINK_PARITY_EN
  output logic             rx_perr,
  inout  wire  [WIDTH:0]   bus,
`else
  inout  wire  [WIDTH-1:0] bus,
`endif
  output logic             dir,
  inout  wire              stb
);

`ifdef BIDIR_LINK_PARITY_EN
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  localparam int CMAX =
    (TURN_CYC > RX_WIN) ? TURN_CYC : RX_WIN;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TURN_LD =
    CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] WIN_LD =
    CW'(RX_WIN - 1);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_word;
  logic [BW-1:0]    bus_out;
  logic [BW-1:0]    bus_in;
  logic             stb_in;
  logic             stb_hit;
  logic             cnt_zero;
  logic             accept;

  // An X or Z strobe never counts as a response.
  assign stb_hit  = (stb_in === 1'b1);
  assign cnt_zero = (cnt == '0);
  assign accept   = tx_valid && tx_ready;

`ifdef BIDIR_LINK_PARITY_EN
  assign bus_out = {even_par(64'(tx_word)), tx_word};
`else
  assign bus_out = tx_word;
`endif

  // State register; reset drops dir at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = DRIVE;
      DRIVE:   state_nx = TURN;
      TURN:    if (cnt_zero) state_nx = LISTEN;
      LISTEN:  if (stb_hit || cnt_zero) state_nx = GAP;
      GAP:     if (cnt_zero) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    tx_ready = 1'b0;
    dir      = 1'b0;
    unique case (1'b1)
      state == IDLE:  tx_ready = 1'b1;
      state == DRIVE: dir      = 1'b1;
      default: ;
    endcase
  end

  // Shared down-counter, reloaded on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= (state_nx == LISTEN) ? WIN_LD : TURN_LD;
    end else if (!cnt_zero) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Request word latch; cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_word <= '0;
    end else if (accept) begin
      tx_word <= tx_data;
    end
  end

  // Response capture and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      timeout  <= 1'b0;
`ifdef BIDIR_LINK_PARITY_EN
      rx_perr  <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      timeout  <= 1'b0;
`ifdef BIDIR_LINK_PARITY_EN
      rx_perr  <= 1'b0;
`endif
      if (state == LISTEN) begin
        if (stb_hit) begin
          rx_data  <= bus_in[WIDTH-1:0];
          rx_valid <= 1'b1;
`ifdef BIDIR_LINK_PARITY_EN
          rx_perr  <= bus_in[WIDTH] !=
            even_par(64'(bus_in[WIDTH-1:0]));
`endif
        end else if (cnt_zero) begin
          timeout <= 1'b1;
        end
      end
    end
  end

  bidir_link_pad #(
    .W (BW)
  ) u_pad (
    .dir  (dir),
    .dout (bus_out),
    .sout (1'b1),
    .din  (bus_in),
    .sin  (stb_in),
    .bus  (bus),
    .stb  (stb)
  );

endmodule

// File: tb/tb_bidir_link_ctrl.sv
// tb_bidir_link_ctrl: directed vector table plus corner sequences.
// Released lines are pulled: bus reads all ones, stb reads zero.
module tb_bidir_link_ctrl;

  localparam int W = 8;
`ifdef BIDIR_LINK_PARITY_EN
  localparam int BW = W + 1;
`else
  localparam int BW = W;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [W-1:0]  tx_data  = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic          timeout;
  logic          dir;
`ifdef BIDIR_LINK_PARITY_EN
  logic          rx_perr;
`endif

  logic          peer_en  = 1'b0;
  logic          peer_stb = 1'b0;
  logic [BW-1:0] peer_bus = '0;

  tri1 [BW-1:0]  bus;
  tri0           stb;

  assign bus = peer_en ? peer_bus : {BW{1'bz}};
  assign stb = peer_en ? peer_stb : 1'bz;

  always #5 clk = ~clk;

  bidir_link_ctrl #(
    .WIDTH    (8),
    .TURN_CYC (1),
    .RX_WIN   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .timeout  (timeout),
`ifdef BIDIR_LINK_PARITY_EN
    .rx_perr  (rx_perr),
`endif
    .bus      (bus),
    .dir      (dir),
    .stb      (stb)
  );

  typedef struct {
    logic        txv;
    logic [7:0]  txd;
    logic        pen;
    logic [7:0]  pd;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic logic [20:0] ex(
    input logic       d,
    input logic [7:0] b,
    input logic       s,
    input logic       r,
    input logic       v,
    input logic       t,
    input logic [7:0] rd
  );
    return {d, b, s, r, v, t, rd};
  endfunction

  function automatic logic [20:0] obs();
    return {dir, bus[7:0], stb, tx_ready,
            rx_valid, timeout, rx_data};
  endfunction

  task automatic add(
    input logic        txv,
    input logic [7:0]  txd,
    input logic        pen,
    input logic [7:0]  pd,
    input logic [20:0] e
  );
    vec_t v;
    v.txv = txv;
    v.txd = txd;
    v.pen = pen;
    v.pd  = pd;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    nvec++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %h want %h",
               nm, act, req);
    end
  endtask

  initial begin
    // normal transfer: A5 out, 3C back on 2nd LISTEN cycle
    add(1, 8'hA5, 0, 8'h00, ex(0, 8'hFF, 0, 1, 0, 0, 8'h00));
    add(0, 8'h00, 0, 8'h00, ex(1, 8'hA5, 1, 0, 0, 0, 8'h00));
    add(0, 8'h00, 0, 8'h00, ex(0, 8'hFF, 0, 0, 0, 0, 8'h00));
    add(0, 8'h00, 0, 8'h00, ex(0, 8'hFF, 0, 0, 0, 0, 8'h00));
    add(0, 8'h00, 1, 8'h3C, ex(0, 8'h3C, 1, 0, 0, 0, 8'h00));
    add(0, 8'h00, 0, 8'h00, ex(0, 8'hFF, 0, 0, 1, 0, 8'h3C));
    add(0, 8'h00, 0, 8'h00, ex(0, 8'hFF, 0, 1, 0, 0, 8'h3C));
    // no response: 11 out, four silent LISTEN cycles
    add(1, 8'h11, 0, 8'h00, ex(0, 8'hFF, 0, 1, 0, 0, 8'h3C));
    add(0, 8'h00, 0, 8'h00, ex(1, 8'h11, 1, 0, 0, 0, 8'h3C));
    add(0, 8'h00, 0, 8'h00, ex(0, 8'hFF, 0, 0, 0, 0, 8'h3C));
    for (int i = 0; i < 4; i++) begin
      add(0, 8'h00, 0, 8'h00,
          ex(0, 8'hFF, 0, 0, 0, 0, 8'h3C));
    end
    add(0, 8'h00, 0, 8'h00, ex(0, 8'hFF, 0, 0, 0, 1, 8'h3C));
    add(0, 8'h00, 0, 8'h00, ex(0, 8'hFF, 0, 1, 0, 0, 8'h3C));
    // peer strobes in IDLE, TURN and GAP are ignored
    add(0, 8'h00, 1, 8'hFF, ex(0, 8'hFF, 1, 1, 0, 0, 8'h3C));
    add(1, 8'h22, 0, 8'h00, ex(0, 8'hFF, 0, 1, 0, 0, 8'h3C));
    add(0, 8'h00, 0, 8'h00, ex(1, 8'h22, 1, 0, 0, 0, 8'h3C));
    add(0, 8'h00, 1, 8'hFF, ex(0, 8'hFF, 1, 0, 0, 0, 8'h3C));
    for (int i = 0; i < 4; i++) begin
      add(0, 8'h00, 0, 8'h00,
          ex(0, 8'hFF, 0, 0, 0, 0, 8'h3C));
    end
    add(0, 8'h00, 1, 8'hFF, ex(0, 8'hFF, 1, 0, 0, 1, 8'h3C));
    add(0, 8'h00, 0, 8'h00, ex(0, 8'hFF, 0, 1, 0, 0, 8'h3C));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out",
        32'({dir, bus[7:0], stb, rx_valid, timeout, rx_data}),
        32'({1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_rel",
        32'({tx_ready, dir, rx_valid, timeout}),
        32'(4'b1000));

    // table
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      tx_valid = tbl[i].txv;
      tx_data  = tbl[i].txd;
      peer_en  = tbl[i].pen;
      peer_stb = tbl[i].pen;
      peer_bus = BW'(tbl[i].pd);
      #1;
      chk($sformatf("vec%0d", i),
          32'(obs()), 32'(tbl[i].exp));
    end

    // reset asserted in the middle of DRIVE
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    peer_en  = 1'b0;
    peer_stb = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    #1;
    chk("mid_drive",
        32'({dir, bus[7:0], stb}),
        32'({1'b1, 8'h5A, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("mid_release",
        32'({dir, bus[7:0], stb}),
        32'({1'b0, 8'hFF, 1'b0}));
    chk("mid_rxdata", 32'(rx_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset",
        32'({tx_ready, dir, rx_valid, timeout}),
        32'(4'b1000));
    @(negedge clk);
    #1;
    chk("post_idle",
        32'({tx_ready, dir, bus[7:0], stb}),
        32'({1'b1, 1'b0, 8'hFF, 1'b0}));

`ifdef BIDIR_LINK_PARITY_EN
    // parity: 03 goes out with parity 0; 07 with parity 0 is bad
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h03;
    @(negedge clk);
    tx_valid = 1'b0;
    #1;
    chk("par_drive",
        32'({dir, stb, bus}),
        32'({1'b1, 1'b1, 9'h003}));
    @(negedge clk);
    @(negedge clk);
    peer_en  = 1'b1;
    peer_stb = 1'b1;
    peer_bus = 9'h007;
    @(negedge clk);
    peer_en  = 1'b0;
    peer_stb = 1'b0;
    #1;
    chk("par_err",
        32'({rx_valid, rx_perr, rx_data}),
        32'({1'b1, 1'b1, 8'h07}));
    @(negedge clk);
    #1;
    chk("par_clear",
        32'({rx_valid, rx_perr, tx_ready}),
        32'(3'b001));
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
